// File: rtl/sprite_line_renderer_if.sv
// sprite_line_renderer_if: object request, sprite-ROM and line-buffer signals; hflip exists only with SPRITE_HFLIP_EN
interface sprite_line_renderer_if #(
  parameter int COLOR_W = 8,
  parameter int ROM_AW = 15
);
  logic [9:0] ycoor;
  logic [23:0] object_info;
`ifdef SPRITE_HFLIP_EN
  logic hflip;
`endif
  logic start;
  logic [COLOR_W-1:0] rom_data;
  logic [ROM_AW-1:0] sprite_addr;
  logic [9:0] buf_addr;
  logic [COLOR_W-1:0] buf_data;
  logic buf_we;
  logic busy;
  logic ready;
  modport master(
`ifdef SPRITE_HFLIP_EN
    output hflip,
`endif
    output ycoor, object_info, start, rom_data,
    input sprite_addr, buf_addr, buf_data, buf_we, busy, ready
  );
  modport slave(
`ifdef SPRITE_HFLIP_EN
    input hflip,
`endif
    input ycoor, object_info, start, rom_data,
    output sprite_addr, buf_addr, buf_data, buf_we, busy, ready
  );
endinterface

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: draws one sprite row into the line buffer with clipping and colour keying; SPRITE_HFLIP_EN adds horizontal mirroring
module sprite_line_renderer #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int NUM_SPRITES = 32,
  parameter int SCREEN_W = 640,
  parameter int COLOR_W = 8,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 8'hFF,
  parameter int ROM_AW = $clog2(NUM_SPRITES*SPRITE_W*SPRITE_H)
) (
  input logic clk50,
  input logic reset,
  sprite_line_renderer_if.slave bus
);
  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);
  localparam int IW = $clog2(NUM_SPRITES);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] c_q, c_d, src_col;
  logic valid_q, valid_d;
  logic [10:0] dst_q, dst_d;
  logic [9:0] y_top, diff;
  logic hit;
  assign y_top = {1'b0, bus.object_info[8:0]};
  assign diff = bus.ycoor - y_top;
  assign hit = bus.ycoor >= y_top && diff < 10'(SPRITE_H);
`ifdef SPRITE_HFLIP_EN
  assign src_col = c_q ^ {CW{bus.hflip}};
`else
  assign src_col = c_q;
`endif
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    valid_d = 1'b0;
    dst_d = dst_q;
    case (state_q)
      IDLE: begin
        c_d = '0;
        if (bus.start) state_d = hit ? FETCH : DONE;
      end
      FETCH: begin
        c_d = c_q + 1'b1;
        valid_d = 1'b1;
        dst_d = {1'b0, bus.object_info[18:9]} + 11'(c_q);
        if (c_q == CW'(SPRITE_W-1)) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q <= IDLE;
      c_q <= '0;
      valid_q <= 1'b0;
      dst_q <= '0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      valid_q <= valid_d;
      dst_q <= dst_d;
    end
  end
  // ROM answers one cycle after the address, so the write uses the captured column
  assign bus.sprite_addr = state_q == FETCH ? {bus.object_info[19 +: IW], diff[RW-1:0], src_col} : '0;
  assign bus.buf_addr = dst_q[9:0];
  assign bus.buf_data = bus.rom_data;
  assign bus.buf_we = valid_q && dst_q < 11'(SCREEN_W) && bus.rom_data != TRANSPARENT;
  assign bus.busy = state_q == FETCH || state_q == DRAIN;
  assign bus.ready = state_q == DONE;
endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer: vector table plus write scoreboard for sprite_line_renderer
module tb_sprite_line_renderer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int mode = 0;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  sprite_line_renderer_if bus();
  sprite_line_renderer dut(.clk50(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [9:0] ycoor;
    logic [9:0] x;
    logic [8:0] y;
    logic [4:0] idx;
    int mode;
    bit flip;
    int rdy;
    int writes;
    logic [14:0] addr0;
  } vec_t;
  typedef struct {
    int cyc;
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;
  vec_t vecs[9];
  logic [14:0] aq[$];
  wr_t wq[$];
  function automatic logic [7:0] rom_fn(input logic [14:0] a, input int m);
    if (m == 0) return 8'h12;
    if (m == 1) return a[0] ? (8'h80 | {3'b0, a[4:0]}) : 8'hFF;
    return 8'h40 + {3'b0, a[4:0]};
  endfunction
  always @(posedge clk) bus.rom_data <= rom_fn(bus.sprite_addr, mode);
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic run_obj(input vec_t v);
    logic [14:0] a;
    logic [7:0] d;
    logic [10:0] dst;
    wr_t w;
    bit fl;
    int rdy, nw;
    fl = 1'b0;
`ifdef SPRITE_HFLIP_EN
    fl = v.flip;
    bus.hflip = v.flip;
`endif
    mode = v.mode;
    bus.ycoor = v.ycoor;
    bus.object_info = {v.idx, v.x, v.y};
    aq.delete();
    wq.delete();
    if (v.ycoor >= v.y && v.ycoor - v.y < 32)
      for (int c = 0; c < 32; c++) begin
        a = {v.idx, 5'(v.ycoor - v.y), fl ? 5'(31 - c) : 5'(c)};
        aq.push_back(a);
        d = rom_fn(a, v.mode);
        dst = 11'(v.x) + 11'(c);
        if (dst < 11'd640 && d != 8'hFF) wq.push_back('{c + 2, dst[9:0], d});
      end
    bus.start = 1'b1;
    @(posedge clk);
    rdy = 0;
    nw = 0;
    for (int cyc = 1; cyc <= 60 && rdy == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk("first_addr", 32'(bus.sprite_addr), 32'(v.addr0));
      if (aq.size() > 0) chk("sprite_addr", 32'(bus.sprite_addr), 32'(aq.pop_front()));
      chk("busy", 32'(bus.busy), 32'(cyc <= 33 && v.rdy == 34));
      if (bus.buf_we) begin
        nw++;
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("write_cycle", cyc, w.cyc);
          chk("buf_addr", 32'(bus.buf_addr), 32'(w.a));
          chk("buf_data", 32'(bus.buf_data), 32'(w.d));
        end
      end
      if (bus.ready) rdy = cyc;
    end
    chk("ready_cycle", rdy, v.rdy);
    chk("write_count", nw, v.writes);
    chk("writes_pending", wq.size(), 0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus.ready), 0);
  endtask
  initial begin
    logic [14:0] flip_a0;
    flip_a0 = 15'h1140;
`ifdef SPRITE_HFLIP_EN
    flip_a0 = 15'h115F;
    bus.hflip = 1'b0;
`endif
    vecs[0] = '{10'd100, 10'd200, 9'd90, 5'd3, 0, 1'b0, 34, 32, 15'h0D40};
    vecs[1] = '{10'd50, 10'd200, 9'd60, 5'd3, 0, 1'b0, 1, 0, 15'h0000};
    vecs[2] = '{10'd100, 10'd620, 9'd90, 5'd5, 0, 1'b0, 34, 20, 15'h1540};
    vecs[3] = '{10'd100, 10'd300, 9'd90, 5'd7, 1, 1'b0, 34, 16, 15'h1D40};
    vecs[4] = '{10'd90, 10'd0, 9'd90, 5'd1, 2, 1'b0, 34, 32, 15'h0400};
    vecs[5] = '{10'd121, 10'd10, 9'd90, 5'd2, 2, 1'b0, 34, 32, 15'h0BE0};
    vecs[6] = '{10'd122, 10'd10, 9'd90, 5'd2, 2, 1'b0, 1, 0, 15'h0000};
    vecs[7] = '{10'd100, 10'd1023, 9'd90, 5'd0, 0, 1'b0, 34, 0, 15'h0140};
    vecs[8] = '{10'd100, 10'd0, 9'd90, 5'd4, 2, 1'b1, 34, 32, flip_a0};
    bus.start = 1'b0;
    bus.ycoor = '0;
    bus.object_info = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_we", 32'(bus.buf_we), 0);
    chk("rst_sprite_addr", 32'(bus.sprite_addr), 0);
    chk("rst_buf_addr", 32'(bus.buf_addr), 0);
    for (int i = 0; i < 9; i++) run_obj(vecs[i]);
    // abort a row mid-fetch and confirm a clean restart
    mode = 0;
    bus.ycoor = 10'd100;
    bus.object_info = {5'd3, 10'd200, 9'd90};
`ifdef SPRITE_HFLIP_EN
    bus.hflip = 1'b0;
`endif
    bus.start = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    chk("pre_reset_we", 32'(bus.buf_we), 1);
    reset = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("mid_reset_we", 32'(bus.buf_we), 0);
    chk("mid_reset_ready", 32'(bus.ready), 0);
    chk("mid_reset_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(bus.busy), 0);
    run_obj(vecs[0]);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Parametrised successor to the single-sprite line drawer. For one object and one scanline it checks vertical overlap, walks every column of the sprite row, and generates sprite-ROM read addresses. It then writes the returned pixels into the scanline buffer with horizontal clipping, transparency keying and optional horizontal flip. It sits between the object-list sequencer (start/ready handshake) and the line buffer, and runs once per object per line.

## Interface
- SPRITE_W, 32, sprite width in pixels, power of two
- SPRITE_H, 32, sprite height in lines, power of two
- NUM_SPRITES, 32, sprites in ROM, power of two, at most 32
- SCREEN_W, 640, visible pixels per line, at most 1023
- COLOR_W, 8, pixel width
- TRANSPARENT, 8'hFF, colour key that is never written
- ROM_AW, log2(NUM_SPRITES*SPRITE_W*SPRITE_H), ROM address width

Ports:
- clk50  in  1  sole clock
- reset  in  1  synchronous, active-high
- ycoor  in  10  scanline being built
- object_info  in  24  [23:19] sprite index, [18:9] x left edge, [8:0] y top edge; must be held stable from start until ready
- hflip  in  1  mirror the sprite horizontally (only with SPRITE_HFLIP_EN)
- start  in  1  level request
- rom_data  in  COLOR_W  ROM read data, 1-cycle latency
- sprite_addr  out  ROM_AW  {index, row, src_col}
- buf_addr  out  10  line-buffer write address
- buf_data  out  COLOR_W  equals rom_data
- buf_we  out  1  line-buffer write strobe
- busy  out  1  high in FETCH and DRAIN
- ready  out  1  high in DONE

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: column counter c = 0. If start = 1: on a row hit go to FETCH, otherwise go straight to DONE with no writes.
- Row hit: ycoor >= y and (ycoor − y) < SPRITE_H. The row is (ycoor − y) truncated to log2(SPRITE_H) bits.
- FETCH: sprite_addr = {index, row, src_col}, where src_col = c, or SPRITE_W−1−c when flipping. A pipeline stage captures valid = 1 and dst = x + c, computed at 11 bits. c increments each cycle. After c = SPRITE_W−1, go to DRAIN. Every column is issued, none skipped.
- DRAIN: one cycle to retire the last pixel, then DONE.
- Write rule, in the cycle after the address is issued: buf_we = valid && dst < SCREEN_W && rom_data != TRANSPARENT. buf_addr = dst[9:0]. Clipped and transparent pixels produce no write.
- DONE: ready = 1. Stay while start = 1; go to IDLE when start = 0.
- start changing during FETCH or DRAIN is ignored.
- object_info and ycoor are sampled combinationally each cycle; the caller holds them stable.

## Timing
- Reset values: ready 0, busy 0, buf_we 0, sprite_addr 0, buf_addr 0, state IDLE, valid 0.
- Reset mid-operation: state goes to IDLE, and buf_we is 0 from the cycle after the reset edge.
- Row hit with start sampled high at edge k:
  - FETCH in cycles k+1 .. k+SPRITE_W
  - column c write occurs in cycle k+2+c
  - DRAIN in cycle k+SPRITE_W+1
  - ready from cycle k+SPRITE_W+2
- Row miss: ready in cycle k+1.
- ready is Moore (decoded from state). buf_we, buf_addr and buf_data depend combinationally on registered pipeline state plus rom_data.
- Worst-case throughput: SPRITE_W+3 cycles per object, including the return to IDLE.

## Configuration
- SPRITE_HFLIP_EN defined: the hflip port exists and src_col is mirrored when hflip = 1.
- SPRITE_HFLIP_EN undefined: the hflip port is removed and src_col = c always.

## Test plan
- Hit, no clip: ycoor=100, x=200, y=90, index 3, ROM returns colour 8'h12 → sprite_addr runs from {3,10,0} to {3,10,31}, 32 writes to 200..231, ready at k+34.
- Row miss: ycoor=50, y=60 → no buf_we, ready at k+1; start dropped → IDLE, and a restart works.
- Right clip: x=620 → writes only to 620..639, 20 writes, still 32 ROM addresses, ready at k+34.
- Transparency: ROM returns 8'hFF on even columns → only 16 writes, to odd addresses.
- Flip (SPRITE_HFLIP_EN): hflip=1, x=0 → the first issued address has src_col 31 and the write at buf_addr 0 carries column 31 data.
- Reset asserted in cycle k+10 → buf_we 0 from k+11, ready 0, next start behaves as after power-up.
